// File: rtl/ula_operand_stage_if.sv
// Operand-stage bus: upstream decode fields, writeback port and the registered ALU operand handshake.
// The master modport is the instruction source and the result consumer; the slave modport is the stage.
interface ula_operand_stage_if;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] ra1;
  logic [2:0] ra2;
  logic [7:0] imm;
  logic       use_imm;
  logic [2:0] op;
  logic       we;
  logic [2:0] wa;
  logic [7:0] wd;
  logic [7:0] SrcA;
  logic [7:0] SrcB;
  logic [2:0] ULAControl;
  logic       out_valid;
  logic       out_ready;
  logic       illegal_op;
  logic [7:0] issue_count;

  modport master (
    output in_valid, ra1, ra2, imm, use_imm, op, we, wa, wd, out_ready,
    input  in_ready, SrcA, SrcB, ULAControl, out_valid, illegal_op, issue_count
  );

  modport slave (
    input  in_valid, ra1, ra2, imm, use_imm, op, we, wa, wd, out_ready,
    output in_ready, SrcA, SrcB, ULAControl, out_valid, illegal_op, issue_count
  );
endinterface

// File: rtl/ula_operand_stage.sv
// Register-file read plus one output register slice: 1-cycle accept-to-out_valid latency.
// A stalled output holds its operands; in_ready drops while out_valid is high and out_ready is low.
module ula_operand_stage (
  input logic               clk,
  input logic               reset,
  ula_operand_stage_if.slave bus
);

  logic [7:0] rf_q [8];
  logic [7:0] rf_d [8];
  logic [7:0] srca_q, srca_d;
  logic [7:0] srcb_q, srcb_d;
  logic [2:0] ctl_q, ctl_d;
  logic       illegal_q, illegal_d;
  logic       valid_q, valid_d;
  logic [7:0] count_q, count_d;

  logic       wr_en;
  logic       accept;
  logic [7:0] opnd_a;
  logic [7:0] opnd_b;
  logic [7:0] rd_b;

  assign wr_en       = bus.we && (bus.wa != 3'd0);
  assign bus.in_ready = !reset && (!valid_q || bus.out_ready);
  assign accept      = bus.in_valid && bus.in_ready;

  // Same-cycle writeback is forwarded so an operand never sees the stale register value.
  always_comb begin
    opnd_a = 8'h00;
    rd_b   = 8'h00;
    if (bus.ra1 != 3'd0) begin
      opnd_a = (wr_en && bus.wa == bus.ra1) ? bus.wd : rf_q[bus.ra1];
    end
    if (bus.ra2 != 3'd0) begin
      rd_b = (wr_en && bus.wa == bus.ra2) ? bus.wd : rf_q[bus.ra2];
    end
    opnd_b = bus.use_imm ? bus.imm : rd_b;
  end

  always_comb begin
    rf_d = rf_q;
    if (wr_en) begin
      rf_d[bus.wa] = bus.wd;
    end
  end

  always_comb begin
    srca_d    = srca_q;
    srcb_d    = srcb_q;
    ctl_d     = ctl_q;
    illegal_d = illegal_q;
    valid_d   = valid_q;
    count_d   = count_q;
    if (accept) begin
      srca_d    = opnd_a;
      srcb_d    = opnd_b;
      ctl_d     = bus.op;
      illegal_d = (bus.op == 3'b111);
      valid_d   = 1'b1;
      count_d   = count_q + 8'd1;
    end else if (valid_q && bus.out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        rf_q[i] <= 8'h00;
      end
      srca_q    <= 8'h00;
      srcb_q    <= 8'h00;
      ctl_q     <= 3'd0;
      illegal_q <= 1'b0;
      valid_q   <= 1'b0;
      count_q   <= 8'h00;
    end else begin
      rf_q      <= rf_d;
      srca_q    <= srca_d;
      srcb_q    <= srcb_d;
      ctl_q     <= ctl_d;
      illegal_q <= illegal_d;
      valid_q   <= valid_d;
      count_q   <= count_d;
    end
  end

  assign bus.SrcA        = srca_q;
  assign bus.SrcB        = srcb_q;
  assign bus.ULAControl  = ctl_q;
  assign bus.illegal_op  = illegal_q;
  assign bus.out_valid   = valid_q;
  assign bus.issue_count = count_q;

endmodule

// File: tb/tb_ula_operand_stage.sv
// Directed plus randomised bench for ula_operand_stage with a register-file model and an output scoreboard.
module tb_ula_operand_stage;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic       ill;
  } item_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  ula_operand_stage_if b();

  ula_operand_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (b)
  );

  always #5 clk = ~clk;

  int         n_assert = 0;
  int         n_fail = 0;
  item_t      sb[$];
  item_t      last_out = '0;
  logic [7:0] mreg [8];
  logic [7:0] mcnt = 8'h00;
  logic       exp_valid = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rd(input logic [2:0] r);
    if (r == 3'd0) return 8'h00;
    if (b.we && b.wa == r) return b.wd;
    return mreg[r];
  endfunction

  task automatic drv(input logic iv, input logic [2:0] r1, input logic [2:0] r2, input logic [2:0] op,
                     input logic ui, input logic [7:0] imm, input logic we, input logic [2:0] wa,
                     input logic [7:0] wd);
    b.in_valid = iv; b.ra1 = r1; b.ra2 = r2; b.op = op;
    b.use_imm = ui; b.imm = imm; b.we = we; b.wa = wa; b.wd = wd;
  endtask

  // One clock: predict from the model before the edge, compare all outputs #1 after it.
  task automatic tick();
    logic  rdy_m;
    logic  acc;
    item_t it;
    item_t cur;
    #2;
    rdy_m = !reset && (!exp_valid || b.out_ready);
    chk("in_ready", {31'd0, b.in_ready}, {31'd0, rdy_m});
    acc   = b.in_valid && rdy_m;
    it.a  = rd(b.ra1);
    it.b  = b.use_imm ? b.imm : rd(b.ra2);
    it.op = b.op;
    it.ill = (b.op == 3'b111);
    if (reset) begin
      sb.delete();
      for (int i = 0; i < 8; i++) mreg[i] = 8'h00;
      mcnt = 8'h00;
      last_out = '0;
    end else begin
      if (exp_valid && b.out_ready) void'(sb.pop_front());
      if (acc) begin
        sb.push_back(it);
        last_out = it;
        mcnt = mcnt + 8'd1;
      end
      if (b.we && b.wa != 3'd0) mreg[b.wa] = b.wd;
    end
    @(posedge clk);
    #1;
    exp_valid = (sb.size() != 0);
    cur = exp_valid ? sb[0] : last_out;
    chk("out_valid", {31'd0, b.out_valid}, {31'd0, exp_valid});
    chk("issue_count", {24'd0, b.issue_count}, {24'd0, mcnt});
    chk("SrcA", {24'd0, b.SrcA}, {24'd0, cur.a});
    chk("SrcB", {24'd0, b.SrcB}, {24'd0, cur.b});
    chk("ULAControl", {29'd0, b.ULAControl}, {29'd0, cur.op});
    chk("illegal_op", {31'd0, b.illegal_op}, {31'd0, cur.ill});
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mreg[i] = 8'h00;
    b.out_ready = 1'b1;
    drv(1'b1, 3'd1, 3'd2, 3'd5, 1'b0, 8'h11, 1'b1, 3'd1, 8'h77);

    // Reset with a coincident write and accept, both discarded.
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    drv(1'b0, 3'd1, 3'd0, 3'd0, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00);
    tick();
    chk("post_reset_in_ready", {31'd0, b.in_ready}, 32'd1);

    // Plain register read through the stage.
    drv(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 8'h00, 1'b1, 3'd3, 8'h5A);
    tick();
    drv(1'b1, 3'd3, 3'd0, 3'd0, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00);
    tick();
    chk("r029_valid", {31'd0, b.out_valid}, 32'd1);
    chk("r029_srca", {24'd0, b.SrcA}, 32'h5A);
    chk("r029_srcb", {24'd0, b.SrcB}, 32'h00);
    drv(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00);
    tick();

    // Writeback bypass into both operands, then the written value from the file.
    drv(1'b1, 3'd2, 3'd2, 3'd1, 1'b0, 8'h00, 1'b1, 3'd2, 8'h33);
    tick();
    chk("r030_srca", {24'd0, b.SrcA}, 32'h33);
    chk("r030_srcb", {24'd0, b.SrcB}, 32'h33);
    drv(1'b1, 3'd2, 3'd3, 3'd2, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00);
    tick();
    chk("r030_r2", {24'd0, b.SrcA}, 32'h33);
    drv(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00);
    tick();

    // Stall: held outputs must survive writes to the source register.
    b.out_ready = 1'b0;
    drv(1'b1, 3'd4, 3'd5, 3'd3, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00);
    tick();
    drv(1'b1, 3'd4, 3'd4, 3'd6, 1'b0, 8'h00, 1'b1, 3'd4, 8'hFF);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("r031_hold_srca", {24'd0, b.SrcA}, 32'h00);
      chk("r031_hold_ctl", {29'd0, b.ULAControl}, 32'd3);
    end
    b.out_ready = 1'b1;
    drv(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00);
    tick();
    chk("r031_drop", {31'd0, b.out_valid}, 32'd0);
    drv(1'b1, 3'd4, 3'd0, 3'd0, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00);
    tick();
    chk("r031_r4", {24'd0, b.SrcA}, 32'hFF);

    // R0 ignores writes; op 111 passes through and is flagged.
    drv(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 8'h00, 1'b1, 3'd0, 8'hAA);
    tick();
    drv(1'b1, 3'd0, 3'd0, 3'd7, 1'b1, 8'h04, 1'b0, 3'd0, 8'h00);
    tick();
    chk("r032_srca", {24'd0, b.SrcA}, 32'h00);
    chk("r032_srcb", {24'd0, b.SrcB}, 32'h04);
    chk("r032_ctl", {29'd0, b.ULAControl}, 32'd7);
    chk("r032_ill", {31'd0, b.illegal_op}, 32'd1);

    // Random traffic with backpressure and writebacks.
    for (int i = 0; i < 60; i++) begin
      b.out_ready = 1'($urandom_range(0, 1));
      drv(1'($urandom_range(0, 1)), 3'($urandom), 3'($urandom), 3'($urandom), 1'($urandom_range(0, 1)),
          8'($urandom), 1'($urandom_range(0, 1)), 3'($urandom), 8'($urandom));
      tick();
    end

    // 257 back-to-back accepts from a clean counter.
    reset = 1'b1;
    drv(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00);
    tick();
    reset = 1'b0;
    b.out_ready = 1'b1;
    for (int i = 0; i < 257; i++) begin
      drv(1'b1, 3'(i), 3'(i + 1), 3'(i), 1'b0, 8'h00, 1'b1, 3'(i + 2), 8'(i * 3));
      tick();
      chk("r033_valid", {31'd0, b.out_valid}, 32'd1);
    end
    chk("r033_count", {24'd0, b.issue_count}, 32'd1);

    // Reset while a transaction is held under backpressure.
    b.out_ready = 1'b0;
    drv(1'b1, 3'd3, 3'd4, 3'd5, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00);
    tick();
    reset = 1'b1;
    drv(1'b1, 3'd1, 3'd1, 3'd2, 1'b0, 8'h00, 1'b1, 3'd5, 8'h99);
    tick();
    reset = 1'b0;
    chk("r034_valid", {31'd0, b.out_valid}, 32'd0);
    chk("r034_srca", {24'd0, b.SrcA}, 32'h00);
    chk("r034_count", {24'd0, b.issue_count}, 32'h00);
    b.out_ready = 1'b1;
    for (int r = 1; r < 8; r++) begin
      drv(1'b1, 3'(r), 3'(r), 3'd0, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00);
      tick();
      chk("r034_reg_zero", {24'd0, b.SrcA}, 32'h00);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
